mc_control_v2: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 56 +++++
 rtl/mc_alu_dec.sv | 37 +++
 rtl/mc_control_v2.sv | 231 +++++++++++++++++++++++
 tb/tb_mc_control_v2.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS controller: state codes,
// opcode/funct values, ALUcontrol codes and the ALUOp selector.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_IMMWB  = 4'd10,
      ST_JUMP   = 4'd11,
      ST_LOGIEX = 4'd12,
      ST_FAULT  = 4'd13
   } state_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10,
      ALUOP_LOGI  = 2'b11
   } aluop_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   function automatic logic funct_legal(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
             (fn == FN_OR)  || (fn == FN_SLT);
   endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU decoder: maps ALUOp plus instruction fields onto the ALUcontrol code.
module mc_alu_dec
   import mc_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W = 3
) (
   input  aluop_e               alu_op,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   output logic [ALUCTRL_W-1:0] alu_ctrl
);

   logic [2:0] code;

   always_comb begin
      code = ALU_ADD;
      case (alu_op)
         ALUOP_ADD: code = ALU_ADD;
         ALUOP_SUB: code = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  code = ALU_ADD;
               FN_SUB:  code = ALU_SUB;
               FN_AND:  code = ALU_AND;
               FN_OR:   code = ALU_OR;
               FN_SLT:  code = ALU_SLT;
               default: code = ALU_AND;
            endcase
         end
         ALUOP_LOGI: code = (op == OP_ORI) ? ALU_OR : ALU_AND;
         default:    code = ALU_ADD;
      endcase
   end

   assign alu_ctrl = ALUCTRL_W'(code);

endmodule

// File: rtl/mc_control_v2.sv
// Multicycle MIPS controller: FSM, memory wait/timeout counter and fault latch.
// Define INSTR_COUNT_EN to build the retired-instruction counter.
//
// state  | meaning
// FETCH  | read instruction, PC+4, wait for mem_ready
// DECODE | branch target precompute, dispatch on op/funct
// MEMADR | effective address for lw/sw
// MEMRD  | data read, wait for mem_ready
// MEMWB  | load writeback
// MEMWR  | data write, wait for mem_ready
// EXEC   | R-type ALU op
// ALUWB  | R-type writeback
// BRANCH | beq/bne compare and conditional PC update
// ADDIEX | addi ALU op
// IMMWB  | immediate writeback
// JUMP   | PC <- jump target
// LOGIEX | andi/ori ALU op (zero-extended immediate)
// FAULT  | sticky error, exits only via reset
module mc_control_v2
   import mc_ctrl_pkg::*;
#(
   parameter int ALUCTRL_W   = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           op,
   input  logic [5:0]           funct,
   input  logic                 ZeroFlag,
   input  logic                 mem_ready,
   output logic                 IorD,
   output logic                 MemWrite,
   output logic                 MemRead,
   output logic                 IRWrite,
   output logic                 RegDst,
   output logic                 MemtoReg,
   output logic                 RegWrite,
   output logic                 ALUSrcA,
   output logic                 ExtOp,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           PCSrc,
   output logic [ALUCTRL_W-1:0] ALUcontrol,
   output logic                 PCEn,
   output logic                 fault,
   output logic [3:0]           state_o,
   output logic [CNT_W-1:0]     retired
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   aluop_e              alu_op;
   logic                alu_en, mem_wait;
   logic                mem_write_c, ir_write_c, reg_write_c, pc_en_c;
   logic [ALUCTRL_W-1:0] alu_ctrl_dec;

   mc_alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
      .alu_op   (alu_op),
      .op       (op),
      .funct    (funct),
      .alu_ctrl (alu_ctrl_dec)
   );

   always_comb begin
      state_d     = state_q;
      alu_op      = ALUOP_ADD;
      alu_en      = 1'b0;
      mem_wait    = 1'b0;
      IorD        = 1'b0;
      mem_write_c = 1'b0;
      MemRead     = 1'b0;
      ir_write_c  = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      reg_write_c = 1'b0;
      ALUSrcA     = 1'b0;
      ExtOp       = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      pc_en_c     = 1'b0;
      fault       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            alu_en  = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_en_c    = 1'b1;
               state_d    = ST_DECODE;
            end else begin
               mem_wait = 1'b1;
            end
         end
         ST_DECODE: begin
            ALUSrcB = 2'b11;
            alu_en  = 1'b1;
            case (op)
               OP_LW, OP_SW:   state_d = ST_MEMADR;
               OP_RTYPE:       state_d = funct_legal(funct) ? ST_EXEC : ST_FAULT;
               OP_BEQ, OP_BNE: state_d = ST_BRANCH;
               OP_ADDI:        state_d = ST_ADDIEX;
               OP_ANDI, OP_ORI: state_d = ST_LOGIEX;
               OP_J:           state_d = ST_JUMP;
               default:        state_d = ST_FAULT;
            endcase
         end
         ST_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            alu_en  = 1'b1;
            if (op == OP_LW)      state_d = ST_MEMRD;
            else if (op == OP_SW) state_d = ST_MEMWR;
            else                  state_d = ST_FAULT;
         end
         ST_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) state_d = ST_MEMWB;
            else           mem_wait = 1'b1;
         end
         ST_MEMWB: begin
            MemtoReg    = 1'b1;
            reg_write_c = 1'b1;
            state_d     = ST_FETCH;
         end
         ST_MEMWR: begin
            IorD        = 1'b1;
            mem_write_c = 1'b1;
            if (mem_ready) state_d = ST_FETCH;
            else           mem_wait = 1'b1;
         end
         ST_EXEC: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_FUNCT;
            alu_en  = 1'b1;
            state_d = ST_ALUWB;
         end
         ST_ALUWB: begin
            RegDst      = 1'b1;
            reg_write_c = 1'b1;
            state_d     = ST_FETCH;
         end
         ST_BRANCH: begin
            ALUSrcA = 1'b1;
            alu_op  = ALUOP_SUB;
            alu_en  = 1'b1;
            PCSrc   = 2'b01;
            pc_en_c = ((op == OP_BEQ) && ZeroFlag) || ((op == OP_BNE) && !ZeroFlag);
            state_d = ST_FETCH;
         end
         ST_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            alu_en  = 1'b1;
            state_d = ST_IMMWB;
         end
         ST_LOGIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ExtOp   = 1'b1;
            alu_op  = ALUOP_LOGI;
            alu_en  = 1'b1;
            state_d = ST_IMMWB;
         end
         ST_IMMWB: begin
            reg_write_c = 1'b1;
            state_d     = ST_FETCH;
         end
         ST_JUMP: begin
            PCSrc   = 2'b10;
            pc_en_c = 1'b1;
            state_d = ST_FETCH;
         end
         ST_FAULT: begin
            fault = 1'b1;
         end
         default: state_d = ST_FAULT;
      endcase

      // ready in the same cycle as the limit has already taken the exit above
      if (mem_wait && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT))) state_d = ST_FAULT;

      wait_cnt_d = (mem_wait && (state_d == state_q)) ? wait_cnt_q + WAIT_W'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign MemWrite   = mem_write_c & reset;
   assign IRWrite    = ir_write_c  & reset;
   assign RegWrite   = reg_write_c & reset;
   assign PCEn       = pc_en_c     & reset;
   assign ALUcontrol = alu_en ? alu_ctrl_dec : '0;
   assign state_o    = state_q;

`ifdef INSTR_COUNT_EN
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;

   always_comb begin
      retire = 1'b0;
      if (state_d == ST_FETCH) begin
         case (state_q)
            ST_MEMWB, ST_MEMWR, ST_ALUWB, ST_BRANCH, ST_IMMWB, ST_JUMP: retire = 1'b1;
            default: retire = 1'b0;
         endcase
      end
      retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
   end

   always_ff @(posedge clk) begin
      if (!reset) retired_q <= '0;
      else        retired_q <= retired_d;
   end

   assign retired = retired_q;
`else
   assign retired = '0;
`endif

endmodule

// File: tb/tb_mc_control_v2.sv
// Bench for mc_control_v2: builds an expected per-cycle trace instruction by
// instruction, then replays it against the DUT and compares every cycle.
module tb_mc_control_v2;

   localparam int MEM_TIMEOUT = 15;
   localparam int CNT_W       = 32;
`ifdef INSTR_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                  S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9,
                  S_IMMWB = 10, S_JUMP = 11, S_LOGIEX = 12, S_FAULT = 13;

   localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100,
                          O_BNE = 6'b000101, O_ADDI = 6'b001000, O_ANDI = 6'b001100,
                          O_ORI = 6'b001101, O_LW = 6'b100011, O_SW = 6'b101011;

   logic clk = 1'b0;
   logic reset;
   logic [5:0] op, funct;
   logic ZeroFlag, mem_ready;
   logic IorD, MemWrite, MemRead, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUcontrol;
   logic PCEn, fault;
   logic [3:0] state_o;
   logic [CNT_W-1:0] retired;

   always #5 clk = ~clk;

   mc_control_v2 #(.ALUCTRL_W(3), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .ZeroFlag(ZeroFlag),
      .mem_ready(mem_ready), .IorD(IorD), .MemWrite(MemWrite), .MemRead(MemRead),
      .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ExtOp(ExtOp), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
      .ALUcontrol(ALUcontrol), .PCEn(PCEn), .fault(fault), .state_o(state_o),
      .retired(retired)
   );

   typedef struct {
      int               st;
      bit               rst_n;
      logic [5:0]       op;
      logic [5:0]       funct;
      bit               zero;
      bit               ready;
      logic [CNT_W-1:0] ret;
   } cyc_t;

   typedef struct packed {
      logic iord, memwrite, memread, irwrite, regdst, memtoreg, regwrite, alusrca, extop;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] aluctl;
      logic pcen, fault;
   } outs_t;

   cyc_t q[$];
   cyc_t cur;
   bit   cur_valid = 1'b0;
   int   checks = 0, failures = 0;

   int               rst_in = -1;
   bit               aborted;
   logic [CNT_W-1:0] model_ret = '0;
   logic [5:0]       i_op, i_funct;
   bit               i_zero;

   function automatic bit funct_ok(input logic [5:0] f);
      return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   endfunction

   function automatic bit op_known(input logic [5:0] o);
      return o inside {O_R, O_J, O_BEQ, O_BNE, O_ADDI, O_ANDI, O_ORI, O_LW, O_SW};
   endfunction

   function automatic logic [2:0] fn_alu(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b000;
      endcase
   endfunction

   // Output table of the controller, one row per state.
   function automatic outs_t exp_out(input cyc_t c);
      outs_t o = '0;
      case (c.st)
         S_FETCH:  begin o.memread = 1; o.alusrcb = 2'b01; o.aluctl = 3'b010;
                         o.irwrite = c.ready; o.pcen = c.ready; end
         S_DECODE: begin o.alusrcb = 2'b11; o.aluctl = 3'b010; end
         S_MEMADR: begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctl = 3'b010; end
         S_MEMRD:  begin o.iord = 1; o.memread = 1; end
         S_MEMWB:  begin o.memtoreg = 1; o.regwrite = 1; end
         S_MEMWR:  begin o.iord = 1; o.memwrite = 1; end
         S_EXEC:   begin o.alusrca = 1; o.aluctl = fn_alu(c.funct); end
         S_ALUWB:  begin o.regdst = 1; o.regwrite = 1; end
         S_BRANCH: begin o.alusrca = 1; o.aluctl = 3'b110; o.pcsrc = 2'b01;
                         o.pcen = ((c.op == O_BEQ) && c.zero) || ((c.op == O_BNE) && !c.zero); end
         S_ADDIEX: begin o.alusrca = 1; o.alusrcb = 2'b10; o.aluctl = 3'b010; end
         S_IMMWB:  begin o.regwrite = 1; end
         S_JUMP:   begin o.pcsrc = 2'b10; o.pcen = 1; end
         S_LOGIEX: begin o.alusrca = 1; o.alusrcb = 2'b10; o.extop = 1;
                         o.aluctl = (c.op == O_ORI) ? 3'b001 : 3'b000; end
         S_FAULT:  begin o.fault = 1; end
         default: ;
      endcase
      if (!c.rst_n) begin
         o.memwrite = 0; o.irwrite = 0; o.regwrite = 0; o.pcen = 0;
      end
      return o;
   endfunction

   task automatic emit(input int st, input bit rdy);
      cyc_t c;
      if (aborted) return;
      c.st = st; c.op = i_op; c.funct = i_funct; c.ready = rdy;
      c.zero = (st == S_BRANCH) ? i_zero : 1'($urandom);
      c.ret = model_ret; c.rst_n = 1'b1;
      if (rst_in == 0) begin
         c.rst_n = 1'b0; aborted = 1'b1; model_ret = '0;
      end
      if (rst_in >= 0) rst_in--;
      q.push_back(c);
   endtask

   // w idle cycles then ready; past the timeout the access never completes
   task automatic emit_wait(input int st, input int w, output bit ok);
      if (w <= MEM_TIMEOUT) begin
         repeat (w) emit(st, 1'b0);
         emit(st, 1'b1);
         ok = 1'b1;
      end else begin
         repeat (MEM_TIMEOUT + 1) emit(st, 1'b0);
         ok = 1'b0;
      end
   endtask

   task automatic fault_tail();
      repeat (1 + $urandom_range(0, 3)) emit(S_FAULT, 1'($urandom));
      if (!aborted) begin
         rst_in = 0;
         emit(S_FAULT, 1'($urandom));
      end
   endtask

   task automatic run_instr(input logic [5:0] o_, input logic [5:0] f_, input bit z_,
                            input int fw, input int mw, input int rst_at);
      bit ok;
      i_op = o_; i_funct = f_; i_zero = z_; aborted = 1'b0; rst_in = rst_at;
      emit_wait(S_FETCH, fw, ok);
      if (ok) begin
         emit(S_DECODE, 1'($urandom));
         case (o_)
            O_LW:  begin emit(S_MEMADR, 1'($urandom)); emit_wait(S_MEMRD, mw, ok);
                         if (ok) emit(S_MEMWB, 1'($urandom)); end
            O_SW:  begin emit(S_MEMADR, 1'($urandom)); emit_wait(S_MEMWR, mw, ok); end
            O_R:   if (funct_ok(f_)) begin emit(S_EXEC, 1'($urandom)); emit(S_ALUWB, 1'($urandom)); end
                   else ok = 1'b0;
            O_BEQ, O_BNE: emit(S_BRANCH, 1'($urandom));
            O_ADDI: begin emit(S_ADDIEX, 1'($urandom)); emit(S_IMMWB, 1'($urandom)); end
            O_ANDI, O_ORI: begin emit(S_LOGIEX, 1'($urandom)); emit(S_IMMWB, 1'($urandom)); end
            O_J:   emit(S_JUMP, 1'($urandom));
            default: ok = 1'b0;
         endcase
      end
      if (!ok) fault_tail();
      else if (!aborted && CNT_EN) model_ret = model_ret + 1'b1;
      rst_in = -1;
   endtask

   task automatic pin(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: model gives %0d, hand value %0d", nm, act, exp);
      end
   endtask

   function automatic int pick_wait();
      int r = $urandom_range(0, 99);
      if (r < 70) return 0;
      if (r < 90) return $urandom_range(1, 4);
      if (r < 95) return $urandom_range(13, 15);
      return $urandom_range(16, 20);
   endfunction

   always @(negedge clk) begin
      if (cur_valid) begin
         outs_t e, a;
         e = exp_out(cur);
         a = {IorD, MemWrite, MemRead, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp,
              ALUSrcB, PCSrc, ALUcontrol, PCEn, fault};
         checks++;
         if (state_o !== cur.st[3:0]) begin
            failures++;
            $display("FAIL state @%0t: got %0d want %0d", $time, state_o, cur.st);
         end
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL outputs @%0t st=%0d op=%b: got %h want %h", $time, cur.st, cur.op, a, e);
         end
         checks++;
         if (retired !== cur.ret) begin
            failures++;
            $display("FAIL retired @%0t: got %0d want %0d", $time, retired, cur.ret);
         end
      end
   end

   initial begin
      int i0, n;
      outs_t o;
      logic [5:0] rop, rfn;
      reset = 1'b0; op = '0; funct = '0; ZeroFlag = 1'b0; mem_ready = 1'b0;

      // reset cycle with mem_ready high: strobes must stay low
      i_op = '0; i_funct = '0; i_zero = 1'b0; aborted = 1'b0; rst_in = 0;
      emit(S_FETCH, 1'b1);
      rst_in = -1;

      i0 = q.size();
      run_instr(O_LW, 6'd0, 1'b0, 0, 0, -1);
      pin("lw_len", q.size() - i0, 5);
      for (int k = 0; k < 5; k++) pin("lw_state", q[i0 + k].st, k);
      o = exp_out(q[i0 + 4]);
      pin("lw_wb", {o.regwrite, o.memtoreg}, 3);

      run_instr(O_BEQ, 6'd0, 1'b1, 0, 0, -1);
      o = exp_out(q[$]); pin("beq_z1_pcen", o.pcen, 1);
      run_instr(O_BNE, 6'd0, 1'b1, 0, 0, -1);
      o = exp_out(q[$]); pin("bne_z1_pcen", o.pcen, 0);
      run_instr(O_BNE, 6'd0, 1'b0, 0, 0, -1);
      o = exp_out(q[$]); pin("bne_z0_pcen", o.pcen, 1);

      i0 = q.size();
      run_instr(O_ADDI, 6'd0, 1'b0, 3, 0, -1);
      n = 0;
      for (int k = 0; k < 4; k++) begin
         o = exp_out(q[i0 + k]);
         n = n * 4 + o.irwrite * 2 + o.pcen;
      end
      pin("fetch_wait3", n, 3);

      i0 = q.size();
      run_instr(O_SW, 6'd0, 1'b0, 0, 100, -1);
      n = 0;
      foreach (q[k]) if (k >= i0 && q[k].st == S_MEMWR) n++;
      pin("sw_timeout_cycles", n, 16);
      pin("sw_timeout_next", q[i0 + 19].st, 13);
      o = exp_out(q[i0 + 19]);
      pin("sw_timeout_out", {o.fault, o.memwrite}, 2);

      i0 = q.size();
      run_instr(6'b111111, 6'd0, 1'b0, 0, 0, -1);
      pin("bad_op", q[i0 + 2].st, 13);
      pin("bad_op_reset", q[$].rst_n, 0);

      i0 = q.size();
      run_instr(O_R, 6'b000111, 1'b0, 0, 0, -1);
      pin("bad_funct", q[i0 + 2].st, 13);

      run_instr(O_SW, 6'd0, 1'b0, 0, 8, 5);
      pin("rst_memwr_state", q[$].st, 5);
      o = exp_out(q[$]);
      pin("rst_memwr_we", o.memwrite, 0);

      for (int t = 0; t < 300; t++) begin
         int r = $urandom_range(0, 99);
         case ($urandom_range(0, 8))
            0: rop = O_LW;   1: rop = O_SW;   2: rop = O_R;    3: rop = O_BEQ;
            4: rop = O_BNE;  5: rop = O_ADDI; 6: rop = O_ANDI; 7: rop = O_ORI;
            default: rop = O_J;
         endcase
         if (r < 5) begin
            rop = 6'($urandom_range(0, 63));
            if (op_known(rop)) rop = 6'b111111;
         end
         case ($urandom_range(0, 5))
            0: rfn = 6'b100000; 1: rfn = 6'b100010; 2: rfn = 6'b100100;
            3: rfn = 6'b100101; 4: rfn = 6'b101010;
            default: rfn = 6'($urandom_range(0, 63));
         endcase
         run_instr(rop, rfn, 1'($urandom), pick_wait(), pick_wait(),
                   ($urandom_range(0, 99) < 3) ? $urandom_range(0, 8) : -1);
      end
      run_instr(O_J, 6'd0, 1'b0, 0, 0, -1);

      @(posedge clk); #1;
      foreach (q[i]) begin
         reset = q[i].rst_n; op = q[i].op; funct = q[i].funct;
         ZeroFlag = q[i].zero; mem_ready = q[i].ready;
         cur = q[i]; cur_valid = 1'b1;
         @(posedge clk); #1;
      end
      cur_valid = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
